// File: rtl/mips_pkg.sv
// MIPS opcode/funct constants and field encoders used to build instruction tables.
// Pure constants and functions; no clocked logic, no latency, no backpressure.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int unsigned PROG_LEN = 7;

  function automatic logic [31:0] enc_r(input logic [4:0] rs,
                                        input logic [4:0] rt,
                                        input logic [4:0] rd,
                                        input logic [4:0] shamt,
                                        input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0]  op,
                                        input logic [4:0]  rs,
                                        input logic [4:0]  rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_rom_table.sv
// Combinational lookup of the built-in test program; zero and not-in-range above DEPTH.
// Zero latency, no backpressure; wrapped by a register stage in instr_rom.
module instr_rom_table
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  in_range_o
);

  logic [31:0] idx;
  logic [31:0] word;

  assign idx = 32'(addr_i);

  always_comb begin
    word = NOP_WORD;
    case (idx)
      32'd0:   word = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
      32'd1:   word = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd3);
      32'd2:   word = enc_r(5'd1, 5'd2, 5'd3, 5'd0, FN_ADD);
      32'd3:   word = enc_r(5'd1, 5'd2, 5'd4, 5'd0, FN_SUB);
      32'd4:   word = enc_r(5'd1, 5'd2, 5'd5, 5'd0, FN_AND);
      32'd5:   word = enc_r(5'd1, 5'd2, 5'd6, 5'd0, FN_OR);
      32'd6:   word = enc_i(OP_SW, 5'd0, 5'd3, 16'd0);
      default: word = NOP_WORD;
    endcase
  end

  // Gating by in_range also hides program words when DEPTH is configured below PROG_LEN.
  assign in_range_o = (idx < 32'(DEPTH));
  assign data_o     = in_range_o ? DATA_WIDTH'(word) : '0;

endmodule

// File: rtl/instr_rom.sv
// Read-only instruction memory: o_instr/o_valid registered one cycle after i_addr.
// Synchronous active-low reset clears outputs; always accepts an address, no backpressure.
module instr_rom
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic                  o_valid
);

  logic [DATA_WIDTH-1:0] instr_d;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  valid_d;
  logic                  valid_q;

  instr_rom_table #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_table (
    .addr_i     (i_addr),
    .data_o     (instr_d),
    .in_range_o (valid_d)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign o_instr = instr_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_instr_rom.sv
// Bench for instr_rom: directed scenarios plus random fetch/reset traffic vs. a table model.
module tb_instr_rom;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [31:0] instr;
  logic        valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_rom #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32),
    .DEPTH      (64)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_addr  (addr),
    .o_instr (instr),
    .o_valid (valid)
  );

  // Reference program taken straight from the hex listing.
  logic [31:0] prog [7] = '{32'h20010005, 32'h20020003, 32'h00221820, 32'h00222022,
                            32'h00222824, 32'h00223025, 32'hAC030000};

  function automatic logic [31:0] ref_word(input int unsigned a);
    if (a < 7) return prog[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_valid(input int unsigned a);
    return (a < 64) ? 32'd1 : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string tag, input int unsigned a);
    check(tag, instr, ref_word(a));
    check({tag, "_vld"}, {31'b0, valid}, ref_valid(a));
  endtask

  initial begin
    int unsigned a;
    logic        r;

    // Reset held for two edges with a live address.
    rst_n = 1'b0;
    addr  = 16'd3;
    tick();
    check("rst1_instr", instr, 32'h0);
    check("rst1_vld", {31'b0, valid}, 32'd0);
    tick();
    check("rst2_instr", instr, 32'h0);
    check("rst2_vld", {31'b0, valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_instr", instr, 32'h00222022);
    check("post_rst_vld", {31'b0, valid}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      addr = 16'(i);
      tick();
      check_fetch($sformatf("seq%0d", i), 32'(i));
    end

    // Address change between edges must not reach the output.
    addr = 16'd0;
    tick();
    addr = 16'd1;
    #3;
    check("lat_hold", instr, 32'h20010005);
    tick();
    check("lat_next", instr, 32'h20020003);

    addr = 16'd7;
    tick();
    check_fetch("nop7", 7);
    addr = 16'd63;
    tick();
    check_fetch("nop63", 63);

    addr = 16'd64;
    tick();
    check_fetch("oor64", 64);
    addr = 16'hFFFF;
    tick();
    check_fetch("oorFFFF", 32'hFFFF);

    // Reset landing mid-stream.
    addr = 16'd5;
    tick();
    check_fetch("mid_fetch5", 5);
    rst_n = 1'b0;
    tick();
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_vld", {31'b0, valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_fetch("mid_release", 5);

    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 11) != 0);
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 6);
        1:       a = $urandom_range(0, 63);
        2:       a = $urandom_range(64, 65535);
        default: a = $urandom_range(0, 65535);
      endcase
      rst_n = r;
      addr  = 16'(a);
      tick();
      if (r) begin
        check_fetch($sformatf("rnd%0d_a%0d", i, a), a);
      end else begin
        check($sformatf("rnd%0d_rst", i), instr, 32'h0);
        check($sformatf("rnd%0d_rst_vld", i), {31'b0, valid}, 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
